// File: rtl/ifetch_prefetch_queue.sv
// Instruction-fetch prefetch queue: sequential PC, credit-limited req/gnt fetch, {pc,instr} FIFO toward decode.
// Optional performance counters are compiled in with `define IFQ_PERF_CNT_EN.
module ifetch_prefetch_queue #(
  parameter int unsigned        DEPTH     = 4,
  parameter int unsigned        NB_ADDR   = 32,
  parameter int unsigned        NB_WORD   = 32,
  parameter logic [NB_ADDR-1:0] RESET_PC  = '0,
  parameter logic [NB_WORD-1:0] NOP_INSTR = NB_WORD'(32'h0000_0013)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  output logic               o_imem_req,
  output logic [NB_ADDR-1:0] o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [NB_WORD-1:0] i_imem_rdata,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [NB_ADDR-1:0] i_branch_addr,
  output logic               o_valid,
  output logic [NB_WORD-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_pc,
  output logic               o_fetch_busy
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]        o_fetch_cnt,
  output logic [31:0]        o_flush_cnt,
  output logic [31:0]        o_stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  state_e               state_q;
  logic [NB_ADDR-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic [PW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [PW-1:0]        tag_rd_q, tag_wr_q;
  logic [NB_ADDR-1:0]   fifo_pc_q  [DEPTH];
  logic [NB_WORD-1:0]   fifo_ins_q [DEPTH];
  logic [NB_ADDR-1:0]   tag_q      [DEPTH];

  logic credit_ok, issue, resp, discard, push, pop;

  assign credit_ok = (CW'(count_q) + outstanding_q) < CW'(DEPTH);
  assign o_imem_req  = !i_reset && !i_branch_taken && credit_ok;
  assign o_imem_addr = fetch_pc_q;
  assign issue   = o_imem_req && i_imem_gnt;
  assign resp    = i_imem_rvalid;
  assign discard = (drop_q != '0);
  assign push    = resp && !discard && !i_branch_taken;
  assign pop     = o_valid && !i_stall && !i_branch_taken;

  assign o_valid       = (count_q != '0);
  assign o_instruction = o_valid ? fifo_ins_q[rd_ptr_q] : NOP_INSTR;
  assign o_pc          = o_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign o_fetch_busy  = (state_q == S_FLUSH);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    outstanding_d = outstanding_q + CW'(issue) - CW'(resp);
    drop_d        = drop_q;
    if (resp && discard) drop_d = drop_q - CW'(1);
    if (issue) fetch_pc_d = fetch_pc_q + NB_ADDR'(4);
    if (i_branch_taken) begin
      // Every request still in flight after this cycle belongs to the old path,
      // including those issued toward an earlier redirect target.
      fetch_pc_d = {i_branch_addr[NB_ADDR-1:2], 2'b00};
      count_d    = '0;
      drop_d     = outstanding_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= S_RUN;
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      if (issue) tag_wr_q <= tag_wr_q + PW'(1);
      if (resp)  tag_rd_q <= tag_rd_q + PW'(1);
      if (i_branch_taken) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case (state_q)
        S_RUN:   if (drop_d != '0) state_q <= S_FLUSH;
        S_FLUSH: if (drop_d == '0) state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end

  // Storage arrays carry no reset; occupancy and pointers qualify their contents.
  always_ff @(posedge i_clock) begin
    if (!i_reset && issue) tag_q[tag_wr_q] <= fetch_pc_q;
    if (!i_reset && push) begin
      fifo_pc_q[wr_ptr_q]  <= tag_q[tag_rd_q];
      fifo_ins_q[wr_ptr_q] <= i_imem_rdata;
    end
  end

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_fetch_cnt <= '0;
      o_flush_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (push)              o_fetch_cnt <= o_fetch_cnt + 32'd1;
      if (i_branch_taken)    o_flush_cnt <= o_flush_cnt + 32'd1;
      if (o_valid && i_stall) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Scoreboard bench: memory model with in-order variable latency, expected FIFO contents and credit model.
module tb_ifetch_prefetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_imem_gnt = 1'b0, i_imem_rvalid = 1'b0, i_stall = 1'b0, i_branch_taken = 1'b0;
  logic [31:0] i_imem_rdata = '0, i_branch_addr = '0;
  logic        o_imem_req, o_valid, o_fetch_busy;
  logic [31:0] o_imem_addr, o_instruction, o_pc;
  logic        o2_req, o2_valid, o2_busy;
  logic [31:0] o2_addr, o2_ins, o2_pc;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] o_fetch_cnt, o_flush_cnt, o_stall_cnt, o2_fc, o2_flc, o2_sc;
`endif

  always #5 i_clock = ~i_clock;

  ifetch_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_stall(i_stall), .i_branch_taken(i_branch_taken), .i_branch_addr(i_branch_addr),
    .o_valid(o_valid), .o_instruction(o_instruction), .o_pc(o_pc), .o_fetch_busy(o_fetch_busy)
`ifdef IFQ_PERF_CNT_EN
    , .o_fetch_cnt(o_fetch_cnt), .o_flush_cnt(o_flush_cnt), .o_stall_cnt(o_stall_cnt)
`endif
  );

  // Second instance only exercises the fetch-address wrap from a high reset PC.
  ifetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC2)) dut2 (
    .i_clock(i_clock), .i_reset(i_reset), .o_imem_req(o2_req), .o_imem_addr(o2_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_stall(i_stall), .i_branch_taken(i_branch_taken), .i_branch_addr(i_branch_addr),
    .o_valid(o2_valid), .o_instruction(o2_ins), .o_pc(o2_pc), .o_fetch_busy(o2_busy)
`ifdef IFQ_PERF_CNT_EN
    , .o_fetch_cnt(o2_fc), .o_flush_cnt(o2_flc), .o_stall_cnt(o2_sc)
`endif
  );

  typedef struct { logic [31:0] pc; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  req_t        pend[$];
  ent_t        exp_q[$];
  logic [31:0] mpc = '0;
  int          cyc = 0, n2 = 0, lat_lo = 1, lat_hi = 1;
  int          n_chk = 0, n_pass = 0;
  int          fetch_m = 0, flush_m = 0, stall_m = 0;

  always @(posedge i_clock)
    if (!i_reset && dut.count_q > DEPTH) $error("fifo occupancy above DEPTH");

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic cycle(input bit rst, input bit st, input bit gn, input bit br, input logic [31:0] tgt);
    bit          rv, exp_req;
    int          stale_n;
    logic [31:0] rd, a2;
    req_t        r;
    @(negedge i_clock);
    rv = 1'b0;
    rd = '0;
    if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      rd = mem_data(pend[0].pc);
    end
    i_reset = rst; i_stall = st; i_imem_gnt = gn; i_branch_taken = br; i_branch_addr = tgt;
    i_imem_rvalid = rv; i_imem_rdata = rd;
    #1;
    if (rst) begin
      chk("req_in_reset", o_imem_req, 1'b0);
      pend.delete(); exp_q.delete();
      mpc = '0; fetch_m = 0; flush_m = 0; stall_m = 0;
      cyc++;
      return;
    end
    stale_n = 0;
    foreach (pend[i]) if (pend[i].stale) stale_n++;
    exp_req = !br && (exp_q.size() + pend.size() < DEPTH);
    chk("busy", o_fetch_busy, stale_n != 0);
    chk("valid", o_valid, exp_q.size() != 0);
    chk("req", o_imem_req, exp_req);
    if (exp_req) chk("addr", o_imem_addr, mpc);
    if (exp_q.size() == 0) begin
      chk("empty_instr", o_instruction, NOP);
      chk("empty_pc", o_pc, 32'h0);
    end else begin
      chk("head_pc", o_pc, exp_q[0].pc);
      chk("head_instr", o_instruction, exp_q[0].ins);
    end
    if (o2_req && gn) begin
      a2 = RPC2 + 32'(4 * n2);
      if (n2 < 4) chk("wrap_addr", o2_addr, a2);
      n2++;
    end
    if (exp_q.size() != 0 && st) stall_m++;
    if (br) flush_m++;
    if (exp_q.size() != 0 && !st && !br) void'(exp_q.pop_front());
    if (rv) begin
      r = pend.pop_front();
      if (!r.stale && !br) begin
        exp_q.push_back('{pc: r.pc, ins: rd});
        fetch_m++;
      end
    end
    if (exp_req && gn) begin
      pend.push_back('{pc: mpc, due: cyc + int'($urandom_range(lat_hi, lat_lo)), stale: 1'b0});
      mpc = mpc + 32'd4;
    end
    if (br) begin
      exp_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      mpc = tgt;
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] t;
    // Reset, then sequential fetch with single-cycle memory.
    repeat (2) cycle(1, 0, 1, 0, '0);
    repeat (12) cycle(0, 0, 1, 0, '0);
    // Long stall fills the queue and exhausts credit.
    repeat (10) cycle(0, 1, 1, 0, '0);
    repeat (6) cycle(0, 0, 1, 0, '0);
    // Three requests in flight at latency 3, then redirect.
    lat_lo = 3; lat_hi = 3;
    cycle(1, 0, 1, 0, '0);
    repeat (3) cycle(0, 0, 1, 0, '0);
    cycle(0, 0, 1, 1, 32'h100);
    repeat (14) cycle(0, 0, 1, 0, '0);
    // Redirect coinciding with a response and a pop.
    lat_lo = 1; lat_hi = 1;
    cycle(1, 0, 1, 0, '0);
    repeat (4) cycle(0, 0, 1, 0, '0);
    cycle(0, 0, 1, 1, 32'h200);
    repeat (6) cycle(0, 0, 1, 0, '0);
    // Redirect again while still flushing.
    lat_lo = 4; lat_hi = 4;
    repeat (2) cycle(0, 0, 1, 0, '0);
    cycle(0, 0, 1, 1, 32'h300);
    cycle(0, 0, 1, 0, '0);
    cycle(0, 0, 1, 1, 32'h400);
    repeat (12) cycle(0, 0, 1, 0, '0);
    // Random traffic with occasional redirects and a mid-run reset.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 600; i++) begin
      t = $urandom() & 32'hFFFF_FFFC;
      cycle(i == 300, $urandom_range(9, 0) < 3, $urandom_range(9, 0) < 7, $urandom_range(99, 0) < 4, t);
    end
    repeat (10) cycle(0, 0, 1, 0, '0);
`ifdef IFQ_PERF_CNT_EN
    @(negedge i_clock);
    chk("fetch_cnt", o_fetch_cnt, fetch_m);
    chk("flush_cnt", o_flush_cnt, flush_m);
    chk("stall_cnt", o_stall_cnt, stall_m);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
